// File: rtl/mem_load_pkg.sv
// Shared types and default parameter values for the memory-load controller.
package mem_load_pkg;

    localparam int ADDR_W_DEF    = 8;
    localparam int DATA_W_DEF    = 16;
    localparam int CNT_W_DEF     = 4;
    localparam int STALL_MAX_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FIN   = 2'd2,
        ABORT = 2'd3
    } load_state_e;

endpackage

// File: rtl/stall_watchdog.sv
// Saturating stall counter: counts source-idle cycles, flags when the limit is held.
module stall_watchdog
    import mem_load_pkg::*;
#(
    parameter int STALL_MAX = STALL_MAX_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic limit_hit_o
);

    localparam int CW = $clog2(STALL_MAX + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STALL_MAX);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear has priority, increment stops at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Decoded from the register so the abort decision is made on a stable value.
    assign limit_hit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_load_ctrl.sv
// Burst loader: takes word_cnt words from a valid/ready stream into consecutive
// memory addresses, signalling load_mem/done downstream, with stall abort.
module mem_load_ctrl
    import mem_load_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int STALL_MAX = STALL_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_cnt,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              load_mem,
    output logic              done,
    output logic              busy,
    output logic              stall_err
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    load_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              hs;
    logic              wd_clr, wd_inc, limit_hit;

    stall_watchdog #(
        .STALL_MAX (STALL_MAX)
    ) u_wd (
        .clk         (clk),
        .reset_n     (reset_n),
        .clr_i       (wd_clr),
        .inc_i       (wd_inc),
        .limit_hit_o (limit_hit)
    );

    assign wr_ready  = (state_q == LOAD) && (rem_q != '0);
    assign hs        = wr_valid && wr_ready;
    assign mem_we    = hs;
    assign mem_addr  = addr_q;
    assign mem_wdata = wr_data;

    assign load_mem  = (state_q == LOAD);
    assign done      = (state_q == FIN);
    assign stall_err = (state_q == ABORT);
    assign busy      = (state_q != IDLE);

    // Next-state, address/count update and watchdog control.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        wd_clr  = 1'b0;
        wd_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    rem_d   = word_cnt;
                    wd_clr  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (rem_q == '0) begin
                    state_d = FIN;
                end else begin
                    if (hs) begin
                        addr_d = addr_q + 1'b1;
                        rem_d  = rem_q - 1'b1;
                        wd_clr = 1'b1;
                    end else if (!wr_valid) begin
                        wd_inc = 1'b1;
                    end
                    // The final handshake beats a coincident stall limit.
                    if (hs && (rem_q == ONE)) begin
                        state_d = FIN;
                    end else if (limit_hit) begin
                        state_d = ABORT;
                    end
                end
            end
            FIN:     state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, address and remaining-count registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_mem_load_ctrl.sv
// Directed bench for mem_load_ctrl with hand-computed expectations.
module tb_mem_load_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  base_addr;
    logic [3:0]  word_cnt;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic        wr_ready, mem_we, load_mem, done, busy, stall_err;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;

    int total = 0;
    int bad   = 0;

    // Results of the last run_load
    logic [7:0]  waddr[$];
    logic [15:0] wdat[$];
    int          wcyc[$];
    int          ndone, done_cyc, nerr, err_cyc, nload, last_load;
    logic        busyv[64];

    always #5 clk = ~clk;

    mem_load_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .word_cnt  (word_cnt),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .load_mem  (load_mem),
        .done      (done),
        .busy      (busy),
        .stall_err (stall_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] addr_at(input int i);
        return (waddr.size() > i) ? {24'h0, waddr[i]} : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] cyc_at(input int i);
        return (wcyc.size() > i) ? wcyc[i] : 32'hFFFF_FFFF;
    endfunction

    // Issue start in cycle 0, then drive wr_valid from vmask (bit c-1 in cycle c).
    task automatic run_load(input logic [7:0] base, input logic [3:0] cnt,
                            input logic [31:0] vmask, input int ncyc, input bit start_mid);
        waddr.delete(); wdat.delete(); wcyc.delete();
        ndone = 0; done_cyc = -1; nerr = 0; err_cyc = -1; nload = 0; last_load = -1;
        start = 1'b1; base_addr = base; word_cnt = cnt; wr_valid = 1'b0; wr_data = 16'h0;
        tick();
        start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            wr_valid = vmask[c-1];
            wr_data  = 16'hA000 + 16'(c);
            start    = start_mid && (c == 2);
            if (start) begin
                base_addr = 8'h80;
                word_cnt  = 4'd7;
            end
            #1;
            if (mem_we) begin
                waddr.push_back(mem_addr);
                wdat.push_back(mem_wdata);
                wcyc.push_back(c);
            end
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (stall_err) begin
                nerr++;
                if (err_cyc < 0) err_cyc = c;
            end
            if (load_mem) begin
                nload++;
                last_load = c;
            end
            busyv[c] = busy;
            tick();
        end
        wr_valid = 1'b0;
        start    = 1'b0;
    endtask

    initial begin
        int nd, nl;
        reset_n = 1'b0; start = 1'b0; base_addr = '0; word_cnt = '0;
        wr_valid = 1'b1; wr_data = '0;
        #3;
        chk("rst_load_mem", load_mem, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_stall_err", stall_err, 0);
        chk("rst_addr", mem_addr, 0);
        wr_valid = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Basic load
        run_load(8'h10, 4'd3, 32'hFFFF_FFFF, 6, 1'b0);
        chk("basic_nwr", waddr.size(), 3);
        chk("basic_a0", addr_at(0), 32'h10);
        chk("basic_a1", addr_at(1), 32'h11);
        chk("basic_a2", addr_at(2), 32'h12);
        chk("basic_c0", cyc_at(0), 1);
        chk("basic_c2", cyc_at(2), 3);
        chk("basic_d0", (wdat.size() > 0) ? {16'h0, wdat[0]} : 32'hFFFF_FFFF, 32'hA001);
        chk("basic_done_cyc", done_cyc, 4);
        chk("basic_ndone", ndone, 1);
        chk("basic_nload", nload, 3);
        chk("basic_last_load", last_load, 3);
        chk("basic_busy4", busyv[4], 1);
        chk("basic_busy5", busyv[5], 0);
        chk("basic_nerr", nerr, 0);

        // Zero-length load
        run_load(8'h40, 4'd0, 32'hFFFF_FFFF, 4, 1'b0);
        chk("zero_nwr", waddr.size(), 0);
        chk("zero_nload", nload, 1);
        chk("zero_done_cyc", done_cyc, 2);
        chk("zero_ndone", ndone, 1);
        chk("zero_busy3", busyv[3], 0);

        // Address wrap
        run_load(8'hFE, 4'd4, 32'hFFFF_FFFF, 7, 1'b0);
        chk("wrap_nwr", waddr.size(), 4);
        chk("wrap_a0", addr_at(0), 32'hFE);
        chk("wrap_a1", addr_at(1), 32'hFF);
        chk("wrap_a2", addr_at(2), 32'h00);
        chk("wrap_a3", addr_at(3), 32'h01);
        chk("wrap_ndone", ndone, 1);
        chk("wrap_done_cyc", done_cyc, 5);

        // Stall abort: two words, then the source goes quiet
        run_load(8'h00, 4'd5, 32'h0000_0003, 16, 1'b0);
        chk("stall_nwr", waddr.size(), 2);
        chk("stall_nerr", nerr, 1);
        chk("stall_err_cyc", err_cyc, 12);
        chk("stall_ndone", ndone, 0);
        chk("stall_last_load", last_load, 11);

        // Seven-cycle gap must survive
        run_load(8'h60, 4'd3, 32'h0000_0301, 14, 1'b0);
        chk("gap7_nerr", nerr, 0);
        chk("gap7_nwr", waddr.size(), 3);
        chk("gap7_c1", cyc_at(1), 9);
        chk("gap7_a2", addr_at(2), 32'h62);
        chk("gap7_done_cyc", done_cyc, 11);

        // Last word lands in the cycle the stall limit is reached
        run_load(8'h70, 4'd2, 32'h0000_0201, 14, 1'b0);
        chk("tie_nwr", waddr.size(), 2);
        chk("tie_c1", cyc_at(1), 10);
        chk("tie_done_cyc", done_cyc, 11);
        chk("tie_nerr", nerr, 0);

        // Start while busy is ignored
        run_load(8'h20, 4'd3, 32'hFFFF_FFFF, 7, 1'b1);
        chk("sbusy_nwr", waddr.size(), 3);
        chk("sbusy_a2", addr_at(2), 32'h22);
        chk("sbusy_done_cyc", done_cyc, 4);
        chk("sbusy_ndone", ndone, 1);
        chk("sbusy_nload", nload, 3);

        // Reset mid-load
        start = 1'b1; base_addr = 8'h30; word_cnt = 4'd5;
        tick();
        start = 1'b0; wr_valid = 1'b1;
        tick();
        #2;
        chk("mid_pre_load_mem", load_mem, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_load_mem", load_mem, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wr_ready", wr_ready, 0);
        chk("mid_rst_mem_we", mem_we, 0);
        chk("mid_rst_done", done, 0);
        tick();
        wr_valid = 1'b0;
        reset_n  = 1'b1;
        nd = 0; nl = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (done || stall_err) nd++;
            if (load_mem) nl++;
            tick();
        end
        chk("mid_post_done_err", nd, 0);
        chk("mid_post_load_mem", nl, 0);
        run_load(8'h50, 4'd2, 32'hFFFF_FFFF, 5, 1'b0);
        chk("mid_new_nwr", waddr.size(), 2);
        chk("mid_new_a0", addr_at(0), 32'h50);
        chk("mid_new_a1", addr_at(1), 32'h51);
        chk("mid_new_done_cyc", done_cyc, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
